// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit and its fetch buffer.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
// Contents: XLEN/ILEN widths, reset PC default, PC step, NOP encoding,
//           the {pc, instr} buffer entry type and a PC alignment helper.
package instr_fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

  // Canonical NOP, kept here so debug views of bubbles share one encoding.
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  // One fetch buffer entry: the PC and the instruction fetched from it.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Instructions are word aligned; the low two address bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_fetch_fifo.sv
// Fetch buffer: DEPTH-entry synchronous FIFO of {pc, instr} with flush.
// Latency: a written entry is visible at rd_data / non-empty the next cycle.
// Backpressure: caller must not write when full unless reading the same cycle.
// Ports: clk, rst (sync, active high), flush (clears pointers and count),
//        wr_en/wr_data (push), rd_en (pop), rd_data (head entry, registered
//        storage), count/full/empty status.
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  fetch_entry_t  wr_data,
  input  logic          rd_en,
  output fetch_entry_t  rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads as zero out of reset.
  // A flush leaves stale data in place; it is masked by empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register driving a zero-latency ROM, buffered to decode.
// Latency: ROM sample to out_valid is 1 cycle; redirect costs one bubble cycle.
// Backpressure: out_ready low stalls the PC once the buffer fills; head holds.
// Ports: clk, rst (sync, active high); rom_addr/rom_instr (ROM side);
//        redirect_valid/redirect_pc (PC replace + flush); out_valid/out_ready/
//        out_instr/out_pc (decode handshake); fetch_count (accepted handshakes).
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] rom_addr,
  input  logic [ILEN-1:0] rom_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     fetch_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [XLEN-1:0] pc;
  logic            pop;
  logic            push;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;

  assign rom_addr = pc;

  // out_valid comes only from registered buffer state, never from out_ready.
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  // A pop frees a slot in the same cycle, so a full buffer can still accept.
  assign push      = !redirect_valid && (!fifo_full || pop);

  assign wr_entry.pc    = pc;
  assign wr_entry.instr = rom_instr;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= align_pc(redirect_pc);
    end else if (push) begin
      pc <= pc + PC_STEP;
    end
  end

  // A pop coinciding with a redirect was accepted by decode, so it counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
    end else if (pop) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (redirect_valid),
    .wr_en  (push),
    .wr_data(wr_entry),
    .rd_en  (pop),
    .rd_data(head),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign out_instr = head.instr;
  assign out_pc    = head.pc;

  // Push/pop gating must keep the occupancy within the buffer size.
  always @(posedge clk) begin
    if (!rst) begin
      assert (fifo_count <= CW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;
  logic [31:0] rom_addr;
  logic [31:0] rom_instr;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] fetch_count;

  logic [31:0] w_rom_addr;
  logic [31:0] w_rom_instr;
  logic        w_out_valid;
  logic [31:0] w_out_instr;
  logic [31:0] w_out_pc;
  logic [31:0] w_fetch_count;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign rom_instr   = rom_word(rom_addr);
  assign w_rom_instr = rom_word(w_rom_addr);

  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_instr(rom_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fetch_count(fetch_count)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
    .clk(clk), .rst(rst), .rom_addr(w_rom_addr), .rom_instr(w_rom_instr),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_instr(w_out_instr),
    .out_pc(w_out_pc), .fetch_count(w_fetch_count)
  );

  // Leaves the bench at a falling edge with rst just released.
  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
    checks++; if (out_pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h want 0", out_pc); end
    checks++; if (out_instr !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h want 0", out_instr); end
    checks++; if (rom_addr !== 32'd0) begin errors++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
    checks++; if (w_rom_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_wrap_addr: got %h want fffffff8", w_rom_addr); end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid); end
      checks++; if (out_pc !== 32'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", i, out_pc, 32'(4 * i)); end
      checks++; if (out_instr !== rom_word(32'(4 * i))) begin errors++; $display("FAIL stream_instr[%0d]: got %h want %h", i, out_instr, rom_word(32'(4 * i))); end
    end
    @(negedge clk);
    checks++; if (fetch_count !== 32'd8) begin errors++; $display("FAIL stream_count: got %0d want 8", fetch_count); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_addr;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      exp_addr = (k == 1) ? 32'd4 : 32'd8;
      checks++; if (rom_addr !== exp_addr) begin errors++; $display("FAIL bp_rom_addr[%0d]: got %h want %h", k, rom_addr, exp_addr); end
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'd0) begin errors++; $display("FAIL bp_head[%0d]: got valid=%b pc=%h want 1/0", k, out_valid, out_pc); end
      checks++; if (dut.fifo_count !== 2'(k == 1 ? 1 : 2)) begin errors++; $display("FAIL bp_count[%0d]: got %0d want %0d", k, dut.fifo_count, (k == 1 ? 1 : 2)); end
    end
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * j)) begin errors++; $display("FAIL bp_drain[%0d]: got valid=%b pc=%h want 1/%h", j, out_valid, out_pc, 32'(4 * j)); end
    end
    checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL bp_fetch_count: got %0d want 2", fetch_count); end
    out_ready = 1'b0;
  endtask

  task automatic test_redirect();
    do_reset();
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0013;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble: got %b want 0", out_valid); end
    checks++; if (rom_addr !== 32'h10) begin errors++; $display("FAIL redir_target: got %h want 10", rom_addr); end
    checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL redir_pop_counted: got %0d want 1", fetch_count); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_instr !== rom_word(32'h10)) begin errors++; $display("FAIL redir_first: got %b/%h/%h want 1/10/%h", out_valid, out_pc, out_instr, rom_word(32'h10)); end
    @(negedge clk);
    checks++; if (out_pc !== 32'h14) begin errors++; $display("FAIL redir_next: got %h want 14", out_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    @(negedge clk);
    redirect_pc = 32'h0000_0203;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || rom_addr !== 32'h200) begin errors++; $display("FAIL redir_b2b: got valid=%b addr=%h want 0/200", out_valid, rom_addr); end
    checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL redir_b2b_count: got %0d want 3", fetch_count); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin errors++; $display("FAIL redir_b2b_head: got %b/%h want 1/200", out_valid, out_pc); end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000; exp_pc[3] = 32'h0000_0004;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (w_out_valid !== 1'b1 || w_out_pc !== exp_pc[i] || w_out_instr !== rom_word(exp_pc[i])) begin
        errors++; $display("FAIL wrap_pc[%0d]: got %b/%h/%h want 1/%h/%h", i, w_out_valid, w_out_pc, w_out_instr, exp_pc[i], rom_word(exp_pc[i]));
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (rom_addr !== 32'd8) begin errors++; $display("FAIL mid_prefill: got %h want 8", rom_addr); end
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", fetch_count); end
    checks++; if (rom_addr !== 32'd0) begin errors++; $display("FAIL mid_rom_addr: got %h want 0", rom_addr); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'd0) begin errors++; $display("FAIL mid_restart: got %b/%h want 1/0", out_valid, out_pc); end
    out_ready = 1'b0;
  endtask

  task automatic test_stress();
    logic [31:0] exp_pc;
    logic [31:0] mfc;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    logic [31:0] tgt;
    logic        prev_hold;
    logic        after_redir;
    logic        r;
    logic        rv;
    do_reset();
    exp_pc = 32'd0; mfc = 32'd0; prev_hold = 1'b0; after_redir = 1'b0;
    prev_pc = '0; prev_instr = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      checks++; if (fetch_count !== mfc) begin errors++; $display("FAIL stress_count@%0d: got %0d want %0d", cyc, fetch_count, mfc); end
      checks++; if (dut.fifo_count > 2'd2) begin errors++; $display("FAIL stress_occupancy@%0d: got %0d want <=2", cyc, dut.fifo_count); end
      if (after_redir) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stress_bubble@%0d: got %b want 0", cyc, out_valid); end
      end
      if (prev_hold) begin
        checks++; if (out_valid !== 1'b1 || out_pc !== prev_pc || out_instr !== prev_instr) begin
          errors++; $display("FAIL stress_stable@%0d: got %b/%h/%h want 1/%h/%h", cyc, out_valid, out_pc, out_instr, prev_pc, prev_instr);
        end
      end
      if (out_valid === 1'b1) begin
        checks++; if (out_pc !== exp_pc || out_instr !== rom_word(exp_pc)) begin
          errors++; $display("FAIL stress_seq@%0d: got %h/%h want %h/%h", cyc, out_pc, out_instr, exp_pc, rom_word(exp_pc));
        end
      end
      r  = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 15) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
      out_ready = r; redirect_valid = rv; redirect_pc = tgt;
      if (out_valid && r) begin
        mfc = mfc + 32'd1;
        exp_pc = exp_pc + 32'd4;
      end
      if (rv) exp_pc = {tgt[31:2], 2'b00};
      prev_hold = out_valid && !r && !rv;
      prev_pc = out_pc; prev_instr = out_instr;
      after_redir = rv;
      @(negedge clk);
    end
    out_ready = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_midstream();
    test_stress();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
